// File: rtl/pulse_stretch.sv
// Stretches single-cycle event ticks into fixed-width level pulses with a minimum
// low gap between them; ticks arriving mid-pulse/gap are counted and replayed.
module pulse_stretch #(
  parameter int unsigned N = 20,
  parameter int unsigned G = 20,
  parameter int unsigned P = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_in,
  input  logic         clr_ovf,
  output logic         level_out,
  output logic         busy,
  output logic [P-1:0] pend_cnt,
  output logic         overflow
);

  localparam int unsigned CW = (N > G) ? N : G;
  localparam logic [CW-1:0] ON_LOAD  = CW'((64'd1 << N) - 64'd1);
  localparam logic [CW-1:0] GAP_LOAD = CW'((64'd1 << G) - 64'd1);
  localparam logic [P-1:0]  PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [P-1:0]  pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;
  logic          queue_tick;
  logic          drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    queue_tick = 1'b0;
    drop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_in) begin
          state_d = ON;
          cnt_d   = ON_LOAD;
        end
      end
      ON: begin
        queue_tick = tick_in;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          // A queued tick takes priority; a new tick here replaces the consumed one.
          if (pend_q != '0) begin
            state_d = ON;
            cnt_d   = ON_LOAD;
            if (!tick_in) pend_d = pend_q - P'(1);
          end else if (tick_in) begin
            state_d = ON;
            cnt_d   = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d      = cnt_q - CW'(1);
          queue_tick = tick_in;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase

    if (queue_tick) begin
      if (pend_q == PEND_MAX) drop = 1'b1;
      else                    pend_d = pend_q + P'(1);
    end

    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    level_d = (state_d == ON);
    busy_d  = (state_d != IDLE);
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pend_cnt  = pend_q;
  assign overflow  = ovf_q;

endmodule
